// File: rtl/inta_sequencer_pkg.sv
// Shared PIC definitions: IR count, level width, sequencer states and the
// lowest-set-bit helper used by both the resolver and the ISR.
package pic_pkg;

  localparam int PIC_NUM_IR = 8;
  localparam int LVL_W      = 3;

  localparam logic [LVL_W-1:0] SPUR_LVL = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [LVL_W-1:0] idx;
  } lsb_t;

  // Descending scan so the lowest index (highest priority) is the last written.
  function automatic lsb_t lowest_set_bit(input logic [PIC_NUM_IR-1:0] v);
    lsb_t r;
    r.vld = 1'b0;
    r.idx = '0;
    for (int i = PIC_NUM_IR - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.vld = 1'b1;
        r.idx = i[LVL_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Resolver/CPU-facing signal bundle of the INTA sequencer.
// aeoi_mode exists only when INTA_AEOI_EN is defined.
interface inta_sequencer_if;
  logic       int_req;
  logic [2:0] req_level;
  logic       inta;
  logic [4:0] vector_base;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] irr_clr;
  logic [7:0] isr;
  logic [7:0] data_out;
  logic       data_oe;
  logic       busy;
`ifdef INTA_AEOI_EN
  logic       aeoi_mode;

  modport master (
    output int_req, req_level, inta, vector_base, eoi_cmd, eoi_specific, eoi_level, aeoi_mode,
    input  int_out, irr_clr, isr, data_out, data_oe, busy
  );
  modport slave (
    input  int_req, req_level, inta, vector_base, eoi_cmd, eoi_specific, eoi_level, aeoi_mode,
    output int_out, irr_clr, isr, data_out, data_oe, busy
  );
`else
  modport master (
    output int_req, req_level, inta, vector_base, eoi_cmd, eoi_specific, eoi_level,
    input  int_out, irr_clr, isr, data_out, data_oe, busy
  );
  modport slave (
    input  int_req, req_level, inta, vector_base, eoi_cmd, eoi_specific, eoi_level,
    output int_out, irr_clr, isr, data_out, data_oe, busy
  );
`endif
endinterface

// File: rtl/inta_sequencer_isr_reg.sv
// In-service register: set on the first acknowledge, cleared by EOI commands
// and (optionally) automatic EOI. A set always wins over a clear of the same bit.
module isr_reg
  import pic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_set_en,
  input  logic [LVL_W-1:0]      i_set_lvl,
  input  logic                  i_eoi_cmd,
  input  logic                  i_eoi_specific,
  input  logic [LVL_W-1:0]      i_eoi_level,
  input  logic                  i_aeoi_clr,
  input  logic [LVL_W-1:0]      i_aeoi_lvl,
  output logic [PIC_NUM_IR-1:0] o_isr
);

  logic [PIC_NUM_IR-1:0] r_isr;
  logic [PIC_NUM_IR-1:0] w_set_mask;
  logic [PIC_NUM_IR-1:0] w_clr_mask;
  lsb_t                  w_lowest;

  assign w_lowest = lowest_set_bit(r_isr);

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_lvl] = 1'b1;
    if (i_eoi_cmd) begin
      if (i_eoi_specific)    w_clr_mask[i_eoi_level]  = 1'b1;
      else if (w_lowest.vld) w_clr_mask[w_lowest.idx] = 1'b1;
    end
    if (i_aeoi_clr) w_clr_mask[i_aeoi_lvl] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_isr <= '0;
    else     r_isr <= (r_isr & ~w_clr_mask) | w_set_mask;
  end

  assign o_isr = r_isr;

endmodule

// File: rtl/inta_sequencer.sv
// 8259-style INT/INTA sequencer: raises INT, runs the two-pulse acknowledge,
// drives the vector and owns the ISR. Optional macro: INTA_AEOI_EN (auto-EOI).
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int NUM_IR      = PIC_NUM_IR,
  parameter int ACK_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  inta_sequencer_if.slave bus
);

  localparam int CNT_W = 16;

  state_t            r_state, w_state_nxt;
  logic [LVL_W-1:0]  r_lvl, w_lvl_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic              w_set_en, w_vec_load, w_aeoi_clr;
  logic              r_int_out, r_busy, r_data_oe;
  logic [NUM_IR-1:0] r_irr_clr;
  logic [7:0]        r_data_out;
  logic [7:0]        w_isr;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl;
    w_cnt_nxt   = r_cnt;
    w_set_en    = 1'b0;
    w_vec_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.int_req) w_state_nxt = WAIT1;
      end
      WAIT1: begin
        // A request withdrawn before the first pulse becomes a level-7 spurious ack.
        if (bus.inta) begin
          w_state_nxt = WAIT2;
          w_cnt_nxt   = '0;
          w_set_en    = bus.int_req;
          w_lvl_nxt   = bus.int_req ? bus.req_level : SPUR_LVL;
        end
      end
      WAIT2: begin
        if (bus.inta) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_vec_load  = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if ((ACK_TIMEOUT != 0) && (w_cnt_inc == CNT_W'(ACK_TIMEOUT))) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef INTA_AEOI_EN
  logic r_spur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_spur <= 1'b0;
    else if (r_state == WAIT1 && bus.inta) r_spur <= ~bus.int_req;
  end

  // A spurious sequence never set a bit, so there is nothing to auto-clear.
  assign w_aeoi_clr = w_vec_load & bus.aeoi_mode & ~r_spur;
`else
  assign w_aeoi_clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lvl      <= '0;
      r_cnt      <= '0;
      r_int_out  <= 1'b0;
      r_busy     <= 1'b0;
      r_irr_clr  <= '0;
      r_data_oe  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lvl     <= w_lvl_nxt;
      r_cnt     <= w_cnt_nxt;
      r_int_out <= (w_state_nxt == WAIT1);
      r_busy    <= (w_state_nxt != IDLE);
      r_irr_clr <= w_set_en ? (NUM_IR'(1) << bus.req_level) : '0;
      r_data_oe <= w_vec_load;
      if (w_vec_load) r_data_out <= {bus.vector_base, r_lvl};
    end
  end

  isr_reg u_isr_reg (
    .clk            (clk),
    .rst            (rst),
    .i_set_en       (w_set_en),
    .i_set_lvl      (bus.req_level),
    .i_eoi_cmd      (bus.eoi_cmd),
    .i_eoi_specific (bus.eoi_specific),
    .i_eoi_level    (bus.eoi_level),
    .i_aeoi_clr     (w_aeoi_clr),
    .i_aeoi_lvl     (r_lvl),
    .o_isr          (w_isr)
  );

  assign bus.int_out  = r_int_out;
  assign bus.busy     = r_busy;
  assign bus.irr_clr  = r_irr_clr;
  assign bus.isr      = w_isr;
  assign bus.data_out = r_data_out;
  assign bus.data_oe  = r_data_oe;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_inta_sequencer;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  inta_sequencer_if bus();

  inta_sequencer #(.NUM_IR(8), .ACK_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [2:0] lvl;
    logic       ia;
    logic       eoi;
    logic       spec;
    logic [2:0] elvl;
    logic       e_int;
    logic [7:0] e_irr;
    logic [7:0] e_isr;
    logic       e_oe;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  // Reference model: phase 0 = nothing pending, 1 = INT raised, 2 = between pulses.
  int       m_phase, m_lvl, m_wait;
  bit       m_spur, m_oe;
  bit [7:0] m_isr, m_irr, m_data;

  task automatic model_reset();
    m_phase = 0; m_lvl = 0; m_wait = 0; m_spur = 1'b0;
    m_oe = 1'b0; m_isr = 8'h00; m_irr = 8'h00; m_data = 8'h00;
  endtask

  task automatic model_step();
    bit [7:0] nxt, setm, aclr;
    bit       aeoi;
`ifdef INTA_AEOI_EN
    aeoi = bus.aeoi_mode;
`else
    aeoi = 1'b0;
`endif
    setm = 8'h00; aclr = 8'h00; m_irr = 8'h00; m_oe = 1'b0;
    nxt  = m_isr;
    if (bus.eoi_cmd)
      nxt = bus.eoi_specific ? (m_isr & ~(8'd1 << bus.eoi_level)) : (m_isr & (m_isr - 8'd1));
    case (m_phase)
      0: if (bus.int_req) m_phase = 1;
      1: if (bus.inta) begin
           m_phase = 2; m_wait = 0;
           if (bus.int_req) begin
             m_lvl = int'(bus.req_level); m_spur = 1'b0;
             setm = 8'd1 << bus.req_level; m_irr = setm;
           end else begin
             m_lvl = 7; m_spur = 1'b1;
           end
         end
      default: if (bus.inta) begin
           m_phase = 0; m_oe = 1'b1;
           m_data = {bus.vector_base, 3'(m_lvl)};
           if (aeoi && !m_spur) aclr = 8'd1 << m_lvl;
         end else begin
           m_wait++;
           if (TO != 0 && m_wait == TO) m_phase = 0;
         end
    endcase
    m_isr = (nxt & ~aclr) | setm;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_int, input logic [7:0] e_irr,
                         input logic [7:0] e_isr, input logic e_oe, input logic [7:0] e_data,
                         input logic e_busy);
    chk({tag, ".int_out"},  {31'd0, bus.int_out}, {31'd0, e_int});
    chk({tag, ".irr_clr"},  {24'd0, bus.irr_clr}, {24'd0, e_irr});
    chk({tag, ".isr"},      {24'd0, bus.isr},     {24'd0, e_isr});
    chk({tag, ".data_oe"},  {31'd0, bus.data_oe}, {31'd0, e_oe});
    chk({tag, ".data_out"}, {24'd0, bus.data_out}, {24'd0, e_data});
    chk({tag, ".busy"},     {31'd0, bus.busy},    {31'd0, e_busy});
  endtask

  task automatic drive(input logic req, input logic [2:0] lvl, input logic ia,
                       input logic eoi, input logic spec, input logic [2:0] el);
    bus.int_req = req; bus.req_level = lvl; bus.inta = ia;
    bus.eoi_cmd = eoi; bus.eoi_specific = spec; bus.eoi_level = el;
  endtask

  task automatic add(input logic req, input logic [2:0] lvl, input logic ia, input logic eoi,
                     input logic spec, input logic [2:0] el, input logic e_int,
                     input logic [7:0] e_irr, input logic [7:0] e_isr, input logic e_oe,
                     input logic [7:0] e_data, input logic e_busy);
    vec_t v;
    v.req = req; v.lvl = lvl; v.ia = ia; v.eoi = eoi; v.spec = spec; v.elvl = el;
    v.e_int = e_int; v.e_irr = e_irr; v.e_isr = e_isr; v.e_oe = e_oe;
    v.e_data = e_data; v.e_busy = e_busy;
    tbl.push_back(v);
  endtask

  initial begin
    bit aeoi_on;
`ifdef INTA_AEOI_EN
    aeoi_on = 1'b1;
    bus.aeoi_mode = 1'b0;
`else
    aeoi_on = 1'b0;
`endif
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    bus.vector_base = 5'h08;
    model_reset();

    //    req  lvl   inta  eoi   spec  elvl  | int   irr    isr    oe    data   busy
    add(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    add(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 8'h08, 1'b0, 8'h00, 1'b1);
    add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h08, 1'b0, 8'h00, 1'b1);
    add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h08, 1'b0, 8'h00, 1'b1);
    add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h08, 1'b1, 8'h43, 1'b0);
    add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h08, 1'b0, 8'h43, 1'b0);
    add(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 8'h08, 1'b0, 8'h43, 1'b1);
    add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 8'h08, 1'b0, 8'h43, 1'b1);
    add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h08, 1'b0, 8'h43, 1'b1);
    add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h08, 1'b1, 8'h47, 1'b0);
    add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h08, 1'b0, 8'h47, 1'b0);
    add(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 8'h08, 1'b0, 8'h47, 1'b1);
    add(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h20, 8'h28, 1'b0, 8'h47, 1'b1);
    add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h28, 1'b1, 8'h45, 1'b0);
    add(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h20, 1'b0, 8'h45, 1'b0);
    add(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h45, 1'b0);
    add(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h45, 1'b0);
    add(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h45, 1'b1);
    add(1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 8'h04, 8'h04, 1'b0, 8'h45, 1'b1);
    add(1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 8'h00, 8'h04, 1'b1, 8'h42, 1'b0);
    add(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'h00, 8'h00, 1'b0, 8'h42, 1'b0);

    repeat (2) @(negedge clk);
    chk_all("reset", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].lvl, tbl[i].ia, tbl[i].eoi, tbl[i].spec, tbl[i].elvl);
      step();
      chk_all($sformatf("tbl%0d", i), tbl[i].e_int, tbl[i].e_irr, tbl[i].e_isr,
              tbl[i].e_oe, tbl[i].e_data, tbl[i].e_busy);
    end

    // Timeout: only the first pulse arrives; ISR bit survives, no vector.
    drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0); step();
    drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0); step();
    chk_all("to_ack1", 1'b0, 8'h02, 8'h02, 1'b0, 8'h42, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int c = 1; c <= TO; c++) begin
      step();
      chk_all($sformatf("to_w%0d", c), 1'b0, 8'h00, 8'h02, 1'b0, 8'h42, (c < TO));
    end
    drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0); step();
    chk_all("to_late", 1'b0, 8'h00, 8'h02, 1'b0, 8'h42, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd1); step();
    chk_all("to_eoi", 1'b0, 8'h00, 8'h00, 1'b0, 8'h42, 1'b0);

    // Reset in WAIT2 clears everything without a clock edge.
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0); step();
    drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0); step();
    chk_all("rs_w2", 1'b0, 8'h01, 8'h01, 1'b0, 8'h42, 1'b1);
    drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0);
    #2 rst = 1'b1;
    #1 chk_all("rs_async", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("rs_reraise", 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);

    // Auto-EOI (inactive without the macro: the ISR bit then stays set).
`ifdef INTA_AEOI_EN
    bus.aeoi_mode = 1'b1;
`endif
    drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0); step();
    chk_all("ae_ack1", 1'b0, 8'h04, 8'h04, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0); step();
    chk_all("ae_mid", 1'b0, 8'h00, 8'h04, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0); step();
    chk_all("ae_ack2", 1'b0, 8'h00, aeoi_on ? 8'h00 : 8'h04, 1'b1, 8'h42, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd2); step();
    chk_all("ae_eoi", 1'b0, 8'h00, 8'h00, 1'b0, 8'h42, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      bus.int_req      = ($urandom_range(0, 2) != 0);
      bus.req_level    = 3'($urandom);
      bus.inta         = ($urandom_range(0, 2) == 0);
      bus.eoi_cmd      = ($urandom_range(0, 5) == 0);
      bus.eoi_specific = 1'($urandom);
      bus.eoi_level    = 3'($urandom);
      bus.vector_base  = 5'($urandom);
`ifdef INTA_AEOI_EN
      bus.aeoi_mode    = 1'($urandom);
`endif
      step();
      chk_all($sformatf("rnd%0d", n), (m_phase == 1), m_irr, m_isr, m_oe, m_data, (m_phase != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
